// File: rtl/neuron_mac16_if.sv
// Handshake bundle for the FP16 neuron accumulator:
// start/bias/relu setup, operand beat stream and result port.
interface neuron_mac16_if #(
  parameter int tam = 16
);
  logic           start;
  logic [tam-1:0] bias;
  logic           relu_en;
  logic           in_valid;
  logic           in_ready;
  logic [tam-1:0] x;
  logic [tam-1:0] w;
  logic           in_last;
  logic           out_valid;
  logic           out_ready;
  logic [tam-1:0] y;
  logic           busy;

  modport master (
    output start, bias, relu_en,
    output in_valid, x, w, in_last,
    output out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  start, bias, relu_en,
    input  in_valid, x, w, in_last,
    input  out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/neuron_mac16.sv
// Sequential FP16 neuron: multiply-accumulate of a beat stream,
// bias add and optional ReLU, using truncating FP16 units.
module multi16 #(
  parameter int tam = 16
) (
  input  logic           en,
  input  logic [tam-1:0] a,
  input  logic [tam-1:0] b,
  output logic [tam-1:0] p
);
  logic [21:0]       w_ma;
  logic [21:0]       w_mb;
  logic [21:0]       w_prod;
  logic signed [6:0] w_exp;
  logic [9:0]        w_mant;
  logic              w_sign;
  logic              w_unused;

  assign w_ma     = {11'd0, 1'b1, a[9:0]};
  assign w_mb     = {11'd0, 1'b1, b[9:0]};
  assign w_prod   = w_ma * w_mb;
  assign w_sign   = a[15] ^ b[15];
  assign w_unused = ^w_prod[9:0];

  assign w_exp = $signed({2'b00, a[14:10]})
               + $signed({2'b00, b[14:10]})
               - 7'sd15
               + $signed({6'd0, w_prod[21]});

  assign w_mant = w_prod[21] ? w_prod[20:11]
                             : w_prod[19:10];

  always_comb begin
    p = '0;
    if (en && a[14:10] != 5'd0 && b[14:10] != 5'd0) begin
      // underflow flushes to zero, overflow saturates to Inf
      if (w_exp <= 7'sd0)
        p = '0;
      else if (w_exp >= 7'sd31)
        p = {w_sign, 5'h1f, 10'd0};
      else
        p = {w_sign, w_exp[4:0], w_mant};
    end
  end
endmodule

module sum16 #(
  parameter int tam = 16
) (
  input  logic           en,
  input  logic [tam-1:0] a,
  input  logic [tam-1:0] b,
  output logic [tam-1:0] s
);
  logic        w_swap;
  logic [15:0] w_big;
  logic [15:0] w_sml;
  logic [4:0]  w_d;
  logic [10:0] w_mb;
  logic [10:0] w_ms;
  logic [11:0] w_sum;
  logic [10:0] w_dif;
  logic [3:0]  w_sh;
  logic [10:0] w_nrm;
  logic [4:0]  w_eb;
  logic        w_unused;

  assign w_swap = b[14:0] > a[14:0];
  assign w_big  = w_swap ? b : a;
  assign w_sml  = w_swap ? a : b;
  assign w_eb   = w_big[14:10];
  assign w_d    = w_eb - w_sml[14:10];
  assign w_mb   = {1'b1, w_big[9:0]};
  assign w_ms   = {1'b1, w_sml[9:0]} >> w_d;
  assign w_sum  = {1'b0, w_mb} + {1'b0, w_ms};
  assign w_dif  = w_mb - w_ms;
  assign w_nrm  = w_dif << w_sh;
  assign w_unused = w_nrm[10];

  always_comb begin
    w_sh = 4'd0;
    for (int i = 0; i < 11; i++)
      if (w_dif[i]) w_sh = 4'(10 - i);
  end

  always_comb begin
    s = '0;
    if (!en || w_eb == 5'd0)
      s = '0;
    else if (w_sml[14:10] == 5'd0)
      s = w_big;
    else if (w_big[15] == w_sml[15]) begin
      if (!w_sum[11])
        s = {w_big[15], w_eb, w_sum[9:0]};
      else if (w_eb == 5'd30)
        s = {w_big[15], 5'h1f, 10'd0};
      else
        s = {w_big[15], w_eb + 5'd1, w_sum[10:1]};
    end else begin
      // exact cancellation and underflow both give +0
      if (w_dif == 11'd0)
        s = '0;
      else if ({1'b0, w_eb} <= {2'b00, w_sh})
        s = '0;
      else
        s = {w_big[15], w_eb - 5'(w_sh), w_nrm[9:0]};
    end
  end
endmodule

module neuron_mac16 #(
  parameter int tam      = 16,
  parameter int N_INPUTS = 4
) (
  input logic           clk,
  input logic           rst,
  neuron_mac16_if.slave bus
);
  localparam int CW = $clog2(N_INPUTS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_BIAS,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [tam-1:0] r_prod;
  logic           r_prod_v;
  logic [tam-1:0] r_acc;
  logic [tam-1:0] r_bias;
  logic           r_relu;
  logic [CW-1:0]  r_cnt;
  logic           r_last;
  logic [tam-1:0] r_y;
  logic           r_out_valid;

  logic [tam-1:0] w_prod;
  logic [tam-1:0] w_sum;
  logic [tam-1:0] w_sum_b;
  logic [tam-1:0] w_act;
  logic           w_in_ready;
  logic           w_beat;

  assign w_in_ready = (r_state == S_ACC) && !r_last;
  assign w_beat     = bus.in_valid && w_in_ready;

  // one adder serves both accumulation and the bias add
  assign w_sum_b = (r_state == S_BIAS) ? r_bias : r_prod;
  assign w_act   = (r_relu && w_sum[tam-1]) ? '0 : w_sum;

  multi16 #(.tam(tam)) u_mul (
    .en (1'b1),
    .a  (bus.x),
    .b  (bus.w),
    .p  (w_prod)
  );

  sum16 #(.tam(tam)) u_add (
    .en (1'b1),
    .a  (r_acc),
    .b  (w_sum_b),
    .s  (w_sum)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.busy      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_prod      <= '0;
      r_prod_v    <= 1'b0;
      r_acc       <= '0;
      r_bias      <= '0;
      r_relu      <= 1'b0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bias  <= bus.bias;
            r_relu  <= bus.relu_en;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_beat) begin
            r_prod   <= w_prod;
            r_prod_v <= 1'b1;
            r_cnt    <= r_cnt + CW'(1);
            r_last   <= bus.in_last
                     || (r_cnt == CW'(N_INPUTS - 1));
          end else if (r_prod_v) begin
            r_prod_v <= 1'b0;
          end
          if (r_prod_v) begin
            r_acc <= w_sum;
            if (r_last) r_state <= S_BIAS;
          end
        end
        S_BIAS: begin
          r_y         <= w_act;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
